f_fetch_fd_stage: RTL and testbench

Fetch stage plus F/D pipeline register for the five-stage MIPS core. It holds the program counter and drives the instruction-memory address. It selects the next PC from sequential, branch, jump or jr redirects computed in D. It latches the fetched instruction and PC into the D stage, where the instruction splitter and decode logic consume them. The block honours the hazard unit's stall and supports a one-cycle FD flush that inserts a bubble.

---
 rtl/f_fetch_fd_stage.sv | 67 ++++++
 tb/tb_f_fetch_fd_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_fd_stage.sv
// Fetch stage and F/D pipeline register for the five-stage MIPS core.
// Holds the PC, selects the next PC from D-stage redirects, and latches the fetched instruction into D.
module f_fetch_fd_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        fd_flush,
  input  logic [1:0]  npc_sel,
  input  logic        D_br_take,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8
);

  logic [31:0] f_pc;
  logic [31:0] npc;
  logic [31:0] seq_pc;
  logic [31:0] br_target;

  assign seq_pc    = f_pc + 32'd4;
  // Redirects are relative to D_PC: the instruction currently in F is the delay slot.
  assign br_target = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};

  always_comb begin
    npc = seq_pc;
    case (npc_sel)
      2'd0: npc = seq_pc;
      2'd1: npc = D_br_take ? br_target : seq_pc;
      2'd2: npc = {D_PC[31:28], D_imm26, 2'b00};
      2'd3: npc = D_rs_data;
      default: npc = seq_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc <= PC_RESET;
    end else if (!stall) begin
      f_pc <= npc;
    end
  end

  // Flush outranks stall here only; the PC above still freezes on stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D_Instr <= 32'h0;
      D_PC    <= 32'h0;
    end else if (fd_flush) begin
      D_Instr <= 32'h0;
      D_PC    <= 32'h0;
    end else if (!stall) begin
      D_Instr <= i_inst_rdata;
      D_PC    <= f_pc;
    end
  end

  assign i_inst_addr = f_pc;
  assign D_PC8       = D_PC + 32'd8;

endmodule

// File: tb/tb_f_fetch_fd_stage.sv
// Scoreboard bench for f_fetch_fd_stage: directed steps queue expected state, a monitor compares it.
module tb_f_fetch_fd_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        fd_flush;
  logic [1:0]  npc_sel;
  logic        D_br_take;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] D_rs_data;
  logic [31:0] i_inst_rdata;
  logic [31:0] i_inst_addr;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [31:0] D_PC8;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_now;

  f_fetch_fd_stage #(.PC_RESET(32'h0000_3000)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .fd_flush(fd_flush),
    .npc_sel(npc_sel),
    .D_br_take(D_br_take),
    .D_imm16(D_imm16),
    .D_imm26(D_imm26),
    .D_rs_data(D_rs_data),
    .i_inst_rdata(i_inst_rdata),
    .i_inst_addr(i_inst_addr),
    .D_Instr(D_Instr),
    .D_PC(D_PC),
    .D_PC8(D_PC8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one load word at 0x3008, address-derived words elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0000_3008) return 32'h8C01_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  assign i_inst_rdata = imem(i_inst_addr);

  task automatic push_exp(input string name, input logic [31:0] addr,
                          input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] pc8);
    exp_t e;
    e.name = name; e.addr = addr; e.instr = instr; e.pc = pc; e.pc8 = pc8;
    exp_q.push_back(e);
  endtask

  task automatic check_field(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, req);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field(e.name, "i_inst_addr", i_inst_addr, e.addr);
    check_field(e.name, "D_Instr", D_Instr, e.instr);
    check_field(e.name, "D_PC", D_PC, e.pc);
    check_field(e.name, "D_PC8", D_PC8, e.pc8);
  endtask

  // Monitor: after each posedge (sampled at negedge) or on an async-reset probe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or sample_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next posedge.
  task automatic apply_stimulus(input string name, input logic st, input logic fl,
                                input logic [1:0] sel, input logic take,
                                input logic [15:0] i16, input logic [25:0] i26,
                                input logic [31:0] rs, input logic [31:0] e_addr,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic [31:0] e_pc8);
    stall = st; fd_flush = fl; npc_sel = sel; D_br_take = take;
    D_imm16 = i16; D_imm26 = i26; D_rs_data = rs;
    push_exp(name, e_addr, e_instr, e_pc, e_pc8);
    @(negedge clk);
    #1;
  endtask

  // Pulse reset between edges and check the reset state before any posedge.
  task automatic async_reset_probe(input string name);
    reset = 1'b1;
    #1;
    push_exp(name, 32'h0000_3000, 32'h0, 32'h0, 32'h8);
    -> sample_now;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; fd_flush = 1'b0; npc_sel = 2'd0;
    D_br_take = 1'b0; D_imm16 = 16'h0; D_imm26 = 26'h0; D_rs_data = 32'h0;
    #2;
    push_exp("reset", 32'h0000_3000, 32'h0, 32'h0, 32'h8);
    -> sample_now;
    @(negedge clk);
    #1;
    reset = 1'b0;

    apply_stimulus("seq1", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3004, imem(32'h3000), 32'h3000, 32'h3008);
    apply_stimulus("seq2", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3008, imem(32'h3004), 32'h3004, 32'h300C);
    apply_stimulus("br_taken", 0, 0, 2'd1, 1, 16'hFFFE, 26'h0, 32'h0,
                   32'h3000, 32'h8C01_0004, 32'h3008, 32'h3010);
    apply_stimulus("br_not_taken", 0, 0, 2'd1, 0, 16'hFFFE, 26'h0, 32'h0,
                   32'h3004, imem(32'h3000), 32'h3000, 32'h3008);
    apply_stimulus("seq3", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3008, imem(32'h3004), 32'h3004, 32'h300C);
    apply_stimulus("seq4", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h300C, 32'h8C01_0004, 32'h3008, 32'h3010);
    apply_stimulus("seq5", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3010, imem(32'h300C), 32'h300C, 32'h3014);
    apply_stimulus("seq6", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3014, imem(32'h3010), 32'h3010, 32'h3018);
    apply_stimulus("jump", 0, 0, 2'd2, 0, 16'h0, 26'h0000C40, 32'h0,
                   32'h3100, imem(32'h3014), 32'h3014, 32'h301C);
    apply_stimulus("jr", 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'h3FFC,
                   32'h3FFC, imem(32'h3100), 32'h3100, 32'h3108);
    apply_stimulus("seq7", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h4000, imem(32'h3FFC), 32'h3FFC, 32'h4004);
    apply_stimulus("stall1", 1, 0, 2'd1, 1, 16'h0010, 26'h0, 32'h0,
                   32'h4000, imem(32'h3FFC), 32'h3FFC, 32'h4004);
    apply_stimulus("stall2", 1, 0, 2'd1, 1, 16'h0010, 26'h0, 32'h0,
                   32'h4000, imem(32'h3FFC), 32'h3FFC, 32'h4004);
    apply_stimulus("unstall_br", 0, 0, 2'd1, 1, 16'h0010, 26'h0, 32'h0,
                   32'h4040, imem(32'h4000), 32'h4000, 32'h4008);
    apply_stimulus("flush_stall", 1, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h4040, 32'h0, 32'h0, 32'h8);
    apply_stimulus("seq8", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h4044, imem(32'h4040), 32'h4040, 32'h4048);
    apply_stimulus("flush_only", 0, 1, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h4048, 32'h0, 32'h0, 32'h8);

    async_reset_probe("async_reset1");
    apply_stimulus("restart1", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3004, imem(32'h3000), 32'h3000, 32'h3008);
    apply_stimulus("restart2", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3008, imem(32'h3004), 32'h3004, 32'h300C);
    apply_stimulus("restart3", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h300C, 32'h8C01_0004, 32'h3008, 32'h3010);

    stall = 1'b1; npc_sel = 2'd1; D_br_take = 1'b1; D_imm16 = 16'h0040;
    async_reset_probe("async_reset_lw");
    apply_stimulus("resume", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h3004, imem(32'h3000), 32'h3000, 32'h3008);
    apply_stimulus("jr_top", 0, 0, 2'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC,
                   32'hFFFF_FFFC, imem(32'h3004), 32'h3004, 32'h300C);
    apply_stimulus("wrap", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h0000_0000, imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0000_0004);
    apply_stimulus("after_wrap", 0, 0, 2'd0, 0, 16'h0, 26'h0, 32'h0,
                   32'h0000_0004, imem(32'h0), 32'h0, 32'h8);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
